// File: rtl/command_sequencer.sv
// Two-requester round-robin command sequencer feeding a single command_processor.
// Accepted commands are queued with their source id and issued in FIFO order.
module command_sequencer #(
  parameter int CMD_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [CMD_W-1:0]        req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [CMD_W-1:0]        req1_data,
  output logic                    req1_ready,
  input  logic                    flush,
  output logic                    cmd_valid,
  output logic [CMD_W-1:0]        cmd_data,
  output logic                    cmd_src,
  input  logic                    cmd_ready,
  output logic [15:0]             issued0,
  output logic [15:0]             issued1,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic             src;
    logic [CMD_W-1:0] data;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        rr_last;     // 1 when requester 1 holds the most recent grant
  logic        full;
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == (AW+1)'(DEPTH));
  assign can_accept = !rst && !flush && !full;

  // On a tie, the requester that did not win last time is granted.
  assign grant0     = can_accept && req0_valid && (!req1_valid || rr_last);
  assign grant1     = can_accept && req1_valid && (!req0_valid || !rr_last);
  assign accept     = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign cmd_valid = (level != '0) && !rst;
  assign cmd_data  = head.data;
  assign cmd_src   = head.src;
  assign pop       = cmd_valid && cmd_ready;

  assign idle = (level == '0) && !req0_valid && !req1_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_last <= 1'b1;
      issued0 <= '0;
      issued1 <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (!cmd_src && issued0 != 16'hFFFF) issued0 <= issued0 + 16'd1;
        if (cmd_src  && issued1 != 16'hFFFF) issued1 <= issued1 + 16'd1;
      end
      // Accepts are blocked during flush, so aligning rd to wr empties the queue.
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (accept) rr_last <= grant1;
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // level, which reset clears, so stale contents can never be presented.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= '{src: grant1, data: (grant1 ? req1_data : req0_data)};
    end
  end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed-vector bench for command_sequencer with a queue-based scoreboard:
// tests push expected (data, src) pairs, a negedge monitor pops them on every issue.
module tb_command_sequencer;

  localparam int CMD_W = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic [CMD_W-1:0] req0_data  = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [CMD_W-1:0] req1_data  = '0;
  logic             req1_ready;
  logic             flush = 1'b0;
  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_src;
  logic             cmd_ready = 1'b0;
  logic [15:0]      issued0;
  logic [15:0]      issued1;
  logic [2:0]       level;
  logic             idle;

  command_sequencer #(.CMD_W(CMD_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_src    (cmd_src),
    .cmd_ready  (cmd_ready),
    .issued0    (issued0),
    .issued1    (issued1),
    .level      (level),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CMD_W-1:0] data;
    logic             src;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic src, input logic [CMD_W-1:0] d);
    exp_t e;
    e.data = d;
    e.src  = src;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    flush      = 1'b0;
    cmd_ready  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Offers n commands (base+k) from one requester, advancing on each handshake.
  task automatic send(input logic src, input int n, input logic [CMD_W-1:0] base);
    int   k = 0;
    int   guard = 0;
    logic r;
    while (k < n && guard < 4 * n + 50) begin
      if (src) begin
        req1_valid = 1'b1;
        req1_data  = base + k;
      end else begin
        req0_valid = 1'b1;
        req0_data  = base + k;
      end
      @(negedge clk);
      r = src ? req1_ready : req0_ready;
      cyc();
      if (r) k++;
      guard++;
    end
    if (src) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL send_timeout: accepted %0d of %0d", k, n);
    end
  endtask

  // Monitor: every issue to command_processor must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue: got data %h src %0d expected no command", cmd_data, cmd_src);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_data", cmd_data, e.data);
        check("issue_src", 32'(cmd_src), 32'(e.src));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: readies held low even with offers pending, everything cleared.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    cyc();
    cyc();
    @(negedge clk);
    check("rst_level", 32'(level), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_issued0", 32'(issued0), 0);
    check("rst_issued1", 32'(issued1), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;
    #1;
    check("rst_idle", 32'(idle), 1);
    cyc();

    // First tie after reset goes to requester 0.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("tie_ready0", 32'(req0_ready), 1);
    check("tie_ready1", 32'(req1_ready), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();

    // Single command: one-cycle latency, cmd_valid high for exactly one cycle.
    cmd_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 32'h4C36_3800;
    push(1'b0, 32'h4C36_3800);
    @(negedge clk);
    check("single_ready0", 32'(req0_ready), 1);
    check("single_no_bypass", 32'(cmd_valid), 0);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_cmd_valid", 32'(cmd_valid), 1);
    check("single_src", 32'(cmd_src), 0);
    check("single_level", 32'(level), 1);
    cyc();
    @(negedge clk);
    check("single_valid_drop", 32'(cmd_valid), 0);
    check("single_issued0", 32'(issued0), 1);

    // Round-robin: both requesters stream, grants alternate 0,1,0,1,...
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'hA000_0000 + i);
      push(1'b1, 32'hB000_0000 + i);
    end
    begin
      int   i0 = 0;
      int   i1 = 0;
      int   g  = 0;
      logic r0;
      logic r1;
      while ((i0 < 4 || i1 < 4) && g < 40) begin
        req0_valid = (i0 < 4);
        req0_data  = 32'hA000_0000 + i0;
        req1_valid = (i1 < 4);
        req1_data  = 32'hB000_0000 + i1;
        @(negedge clk);
        r0 = req0_ready;
        r1 = req1_ready;
        check("rr_single_grant", 32'(r0 & r1), 0);
        cyc();
        if (r0) i0++;
        if (r1) i1++;
        g++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("rr_accepts", i0 + i1, 8);
    end
    cyc();
    cyc();
    @(negedge clk);
    check("rr_issued0", 32'(issued0), 4);
    check("rr_issued1", 32'(issued1), 4);
    check("rr_level", 32'(level), 0);
    cyc();

    // Full queue: 5 offers, 4 accepts; pop while full does not admit the 5th.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 32'hD000_0000 + i);
    begin
      int   i = 0;
      int   g = 0;
      logic r;
      while (i < 4 && g < 20) begin
        req0_valid = 1'b1;
        req0_data  = 32'hD000_0000 + i;
        @(negedge clk);
        r = req0_ready;
        cyc();
        if (r) i++;
        g++;
      end
      check("full_fill_accepts", i, 4);
    end
    req0_valid = 1'b1;
    req0_data  = 32'hD000_0004;
    @(negedge clk);
    check("full_level", 32'(level), 4);
    check("full_ready0", 32'(req0_ready), 0);
    cyc();
    cmd_ready = 1'b1;
    #1;
    check("full_pop_ready0", 32'(req0_ready), 0);
    cyc();
    @(negedge clk);
    check("full_after_pop_level", 32'(level), 3);
    check("full_after_pop_ready0", 32'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    check("full_accept_pop_level", 32'(level), 3);
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    check("full_drain_level", 32'(level), 0);
    cyc();

    // Flush with simultaneous pop at level 3: pop counted, rest discarded.
    cmd_ready = 1'b0;
    push(1'b1, 32'hE000_0000);
    send(1'b1, 3, 32'hE000_0000);
    @(negedge clk);
    check("flush_pre_level", 32'(level), 3);
    cyc();
    flush      = 1'b1;
    cmd_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 32'h5A5A_5A5A;
    @(negedge clk);
    check("flush_blocks_ready0", 32'(req0_ready), 0);
    cyc();
    flush      = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("flush_level", 32'(level), 0);
    check("flush_cmd_valid", 32'(cmd_valid), 0);
    check("flush_issued1", 32'(issued1), 5);
    check("flush_issued0", 32'(issued0), 9);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("flush_no_stale", 32'(cmd_valid), 0);
    end
    cyc();

    // Reset mid-operation with two commands queued.
    cmd_ready = 1'b0;
    send(1'b0, 2, 32'hF000_0000);
    @(negedge clk);
    check("midrst_pre_level", 32'(level), 2);
    check("midrst_pre_valid", 32'(cmd_valid), 1);
    cyc();
    rst        = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    check("midrst_ready0", 32'(req0_ready), 0);
    cyc();
    rst        = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("midrst_level", 32'(level), 0);
    check("midrst_cmd_valid", 32'(cmd_valid), 0);
    check("midrst_issued0", 32'(issued0), 0);
    check("midrst_issued1", 32'(issued1), 0);
    check("midrst_idle", 32'(idle), 1);
    cyc();

    // Saturation: 65537 issues from requester 1 must stop at 16'hFFFF.
    cmd_ready = 1'b1;
    for (int i = 0; i < 65537; i++) push(1'b1, 32'hC000_0000 + i);
    send(1'b1, 65537, 32'hC000_0000);
    cyc();
    cyc();
    @(negedge clk);
    check("sat_issued1", 32'(issued1), 32'h0000_FFFF);
    check("sat_issued0", 32'(issued0), 0);
    check("sat_level", 32'(level), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
